// File: rtl/ex_div_if.sv
// ex_div_if: request/response bundle between the EX stage and the divider.
//   master (EX side)      : drives start_i, op_i, dividend_i, divisor_i,
//                           reg_waddr_i, abort_i; receives busy_o, ready_o,
//                           result_o, reg_waddr_o.
//   slave  (divider side) : the mirror image of master.
// Signal names keep the divider's point of view (_i into it, _o out of it).
interface ex_div_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      reg_waddr_i;
  logic            abort_i;
  logic            busy_o;
  logic            ready_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      reg_waddr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
    input  busy_o, ready_o, result_o, reg_waddr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
    output busy_o, ready_o, result_o, reg_waddr_o
  );
endinterface

// File: rtl/ex_div.sv
// ex_div: multi-cycle RISC-V DIV/DIVU/REM/REMU unit next to the EX stage.
// Radix-2 restoring division, one quotient bit per cycle, XLEN iterations.
//   clk        : core clock, rising edge
//   rst        : synchronous active-high reset
//   div_if     : ex_div_if.slave
//     start_i/op_i/dividend_i/divisor_i/reg_waddr_i : request from EX
//     abort_i    : pipeline flush, cancels any operation in flight
//     busy_o     : stall request (combinational)
//     ready_o    : one-cycle result pulse
//     result_o   : quotient or remainder (held after the pulse)
//     reg_waddr_o: destination index belonging to result_o
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  div_if
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;     // dividend shifts out the top, quotient in the bottom
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;     // |divisor|
  logic [2:0]      op_q, op_d;
  logic [4:0]      waddr_q, waddr_d;
  logic            neg_q, neg_d;     // negate the selected result at the end
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      out_waddr_q, out_waddr_d;

  // Request decode
  logic            req_signed, req_rem;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, sgn_ovf;

  // One restoring step
  logic [XLEN:0]   rem_shift, diff;
  logic            ge;
  logic [XLEN-1:0] rem_iter, quo_iter, mag, final_res;

  always_comb begin
    req_signed = ~div_if.op_i[0];
    req_rem    = div_if.op_i[1];
    a_neg      = req_signed & div_if.dividend_i[XLEN-1];
    b_neg      = req_signed & div_if.divisor_i[XLEN-1];
    a_abs      = a_neg ? -div_if.dividend_i : div_if.dividend_i;
    b_abs      = b_neg ? -div_if.divisor_i  : div_if.divisor_i;
    div_zero   = (div_if.divisor_i == '0);
    sgn_ovf    = req_signed
               & (div_if.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
               & (div_if.divisor_i == '1);

    // Remainder always stays below |divisor|, so the XLEN+1-bit difference
    // never wraps; its top bit is a clean borrow flag.
    rem_shift  = {rem_q, quo_q[XLEN-1]};
    diff       = rem_shift - {1'b0, dvs_q};
    ge         = ~diff[XLEN];
    rem_iter   = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_iter   = {quo_q[XLEN-2:0], ge};
    mag        = op_q[1] ? rem_iter : quo_iter;
    final_res  = neg_q ? -mag : mag;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    op_d        = op_q;
    waddr_d     = waddr_q;
    neg_d       = neg_q;
    result_d    = result_q;
    out_waddr_d = out_waddr_q;

    unique case (state_q)
      S_IDLE: begin
        if (div_if.start_i && !div_if.abort_i) begin
          op_d    = div_if.op_i;
          waddr_d = div_if.reg_waddr_i;
          quo_d   = a_abs;
          rem_d   = '0;
          dvs_d   = b_abs;
          cnt_d   = '0;
          neg_d   = req_rem ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            result_d    = req_rem ? div_if.dividend_i : '1;
            out_waddr_d = div_if.reg_waddr_i;
            state_d     = S_DONE;
          end else if (sgn_ovf) begin
            result_d    = req_rem ? '0 : div_if.dividend_i;
            out_waddr_d = div_if.reg_waddr_i;
            state_d     = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (div_if.abort_i) begin
          state_d = S_IDLE;
        end else begin
          quo_d = quo_iter;
          rem_d = rem_iter;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            result_d    = final_res;
            out_waddr_d = waddr_q;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Result is complete; a flush here cannot cancel the pulse.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      op_q        <= '0;
      waddr_q     <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_waddr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      op_q        <= op_d;
      waddr_q     <= waddr_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      out_waddr_q <= out_waddr_d;
    end
  end

  // Busy covers the issue cycle and every CALC cycle but drops in DONE, so
  // the EX hold releases exactly when the result is written back.
  assign div_if.busy_o      = ~rst & ~div_if.abort_i
                            & (((state_q == S_IDLE) & div_if.start_i) | (state_q == S_CALC));
  assign div_if.ready_o     = (state_q == S_DONE);
  assign div_if.result_o    = result_q;
  assign div_if.reg_waddr_o = out_waddr_q;

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cycle_cnt = 0;
  exp_t sb[$];

  ex_div_if #(.XLEN(32)) dif();

  ex_div #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive a request at the current negedge (this is the accept cycle).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    exp_t e;
    logic special;
    special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    e.res = model(op, a, b);
    e.wa  = wa;
    e.lat = special ? 1 : 33;
    sb.push_back(e);
    dif.start_i     = 1'b1;
    dif.abort_i     = 1'b0;
    dif.op_i        = op;
    dif.dividend_i  = a;
    dif.divisor_i   = b;
    dif.reg_waddr_i = wa;
    #1;
    chk("busy_at_accept", {31'b0, dif.busy_o}, 32'd1);
  endtask

  // Hold start_i while stalled, catch the ready pulse, compare against the
  // head of the scoreboard; returns positioned at the negedge after DONE.
  task automatic wait_ready(output int ready_cycle);
    int   cyc = 0;
    int   busy_cnt = 0;
    bit   got = 0;
    exp_t e;
    ready_cycle = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (dif.ready_o) got = 1;
      else if (dif.busy_o) busy_cnt++;
    end
    chk("ready_seen", {31'b0, got}, 32'd1);
    dif.start_i = 1'b0;
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      ready_cycle = cycle_cnt;
      chk("result", dif.result_o, e.res);
      chk("waddr", {27'b0, dif.reg_waddr_o}, {27'b0, e.wa});
      chk("latency", 32'(cyc), 32'(e.lat));
      chk("busy_cycles", 32'(busy_cnt + 1), 32'(e.lat));
      chk("busy_in_done", {31'b0, dif.busy_o}, 32'd0);
      $display("[TB] op=%b a=%h b=%h -> result=%h waddr=%0d latency=%0d",
               dif.op_i, dif.dividend_i, dif.divisor_i, dif.result_o, dif.reg_waddr_o, cyc);
    end
    @(negedge clk);
    chk("ready_after_done", {31'b0, dif.ready_o}, 32'd0);
  endtask

  task automatic expect_no_ready(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dif.ready_o) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int t1, t2, tdummy;
    dif.start_i = 0; dif.abort_i = 0; dif.op_i = 0;
    dif.dividend_i = 0; dif.divisor_i = 0; dif.reg_waddr_i = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'b0, dif.ready_o}, 32'd0);
    chk("rst_busy", {31'b0, dif.busy_o}, 32'd0);
    chk("rst_result", dif.result_o, 32'd0);
    chk("rst_waddr", {27'b0, dif.reg_waddr_o}, 32'd0);
    @(negedge clk);

    // Unsigned normal case
    issue(3'b101, 32'd100, 32'd7, 5'd5);      wait_ready(tdummy);
    // Signed with negative dividend
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6); wait_ready(tdummy);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7); wait_ready(tdummy);
    issue(3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd8); wait_ready(tdummy);
    issue(3'b110, 32'd100, 32'hFFFF_FFF9, 5'd9); wait_ready(tdummy);
    // Divide by zero
    issue(3'b101, 32'd5, 32'd0, 5'd10);       wait_ready(tdummy);
    issue(3'b111, 32'd5, 32'd0, 5'd11);       wait_ready(tdummy);
    issue(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd12); wait_ready(tdummy);
    // Signed overflow
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13); wait_ready(tdummy);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14); wait_ready(tdummy);
    // Same operands unsigned are a normal division
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15); wait_ready(tdummy);

    // Abort at iteration 10
    issue(3'b101, 32'd100, 32'd7, 5'd16);
    repeat (11) @(negedge clk);
    dif.abort_i = 1'b1;
    dif.start_i = 1'b0;
    #1;
    chk("busy_during_abort", {31'b0, dif.busy_o}, 32'd0);
    @(negedge clk);
    dif.abort_i = 1'b0;
    chk("busy_after_abort", {31'b0, dif.busy_o}, 32'd0);
    chk("ready_after_abort", {31'b0, dif.ready_o}, 32'd0);
    sb.delete();
    expect_no_ready("no_ready_after_abort", 40);
    $display("[TB] abort during CALC: operation discarded");
    issue(3'b101, 32'd9, 32'd3, 5'd17);        wait_ready(tdummy);

    // Abort in IDLE blocks acceptance
    dif.start_i = 1'b1; dif.abort_i = 1'b1;
    #1;
    chk("busy_abort_idle", {31'b0, dif.busy_o}, 32'd0);
    @(negedge clk);
    dif.start_i = 1'b0; dif.abort_i = 1'b0;
    expect_no_ready("no_accept_with_abort", 40);
    $display("[TB] start with abort in IDLE: not accepted");

    // Reset during CALC
    issue(3'b101, 32'd100, 32'd7, 5'd18);
    repeat (5) @(negedge clk);
    rst = 1'b1; dif.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", {31'b0, dif.ready_o}, 32'd0);
    chk("midrst_busy", {31'b0, dif.busy_o}, 32'd0);
    chk("midrst_result", dif.result_o, 32'd0);
    chk("midrst_waddr", {27'b0, dif.reg_waddr_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    expect_no_ready("no_ready_after_rst", 40);
    $display("[TB] reset during CALC: outputs cleared");

    // Back-to-back REMU
    issue(3'b111, 32'd17, 32'd5, 5'd19);       wait_ready(t1);
    issue(3'b111, 32'd20, 32'd6, 5'd20);       wait_ready(t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle RISC-V M-extension divider for DIV, DIVU, REM and REMU, instantiated beside the EX stage.
- Its busy_o output drives the pipeline controller's stall_from_ex_i input. This freezes PC, IF, ID and EX while a division is in flight.
- Its abort_i input is driven by the controller's flush_o, so a flush cancels an in-flight division.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
- XLEN, 32, operand and result width; the iteration count equals XLEN.

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  EX requests a division; held high while EX is stalled
- op_i  input  3  funct3: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU
- dividend_i  input  XLEN  rs1 value
- divisor_i  input  XLEN  rs2 value
- reg_waddr_i  input  5  destination register index
- abort_i  input  1  cancel the current operation (from flush_o)
- busy_o  output  1  stall request to the pipeline controller
- ready_o  output  1  one-cycle pulse; result_o and reg_waddr_o are valid
- result_o  output  XLEN  quotient or remainder
- reg_waddr_o  output  5  latched destination index

Behaviour:
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - DONE: delivering the result.
- Reset (rst=1 at a clock edge) takes priority over everything:
  - state goes to IDLE;
  - iteration counter, latched operands, op and waddr go to 0;
  - ready_o=0, busy_o=0, result_o=0, reg_waddr_o=0.
  - Reset mid-operation discards the operation with no ready pulse.
- Accept: in IDLE with start_i=1 and abort_i=0, the block latches op_i, dividend_i, divisor_i and reg_waddr_i at the edge.
- Special cases are decided at accept time and go IDLE->DONE directly (ready_o one cycle after accept):
  - divisor==0:
    - DIV/DIVU: result = all ones.
    - REM/REMU: result = dividend.
  - DIV/REM with dividend==0x8000_0000 and divisor==0xFFFF_FFFF:
    - DIV: result = 0x8000_0000.
    - REM: result = 0.
- Normal case: IDLE->CALC.
  - Signed ops take the absolute values of both operands.
  - Quotient sign = sign(dividend) XOR sign(divisor), DIV only.
  - Remainder sign = sign(dividend), REM only.
- CALC performs exactly XLEN iterations, counter 0..XLEN-1. Each iteration:
  - shift the remainder left, bringing in the next dividend MSB;
  - if the remainder >= |divisor|, subtract it and shift a 1 into the quotient, else shift in 0.
  - Use XLEN+1-bit compare and subtract; no overflow is possible.
- After the iteration with counter==XLEN-1, the state goes to DONE. The selected quotient or remainder is conditionally two's-complement negated.
- Latency from the accept edge to ready_o high:
  - normal case: XLEN+1 cycles (33);
  - special cases: 1 cycle.
- DONE lasts exactly one cycle:
  - ready_o=1, result_o and reg_waddr_o valid;
  - the next state is always IDLE;
  - start_i is ignored in DONE.
- result_o and reg_waddr_o hold their last value after DONE; ready_o returns to 0.
- busy_o is combinational: (IDLE & start_i) | CALC, gated by ~abort_i and ~rst.
  - It is high in the accept cycle, so EX stalls in the same cycle it issues.
  - It is low in DONE, so the pipeline advances while ready_o=1.
  - The EX hold therefore ends exactly when the result is written back.
- Back-to-back divisions: the next start_i is seen in IDLE the cycle after DONE and is accepted normally.
- abort_i=1 in any state forces IDLE at the next edge:
  - no ready_o pulse; the partial result is discarded;
  - in IDLE, abort_i blocks acceptance;
  - in DONE, ready_o still asserts that cycle (the result is already complete) and the state still goes to IDLE.
- start_i deasserting during CALC without abort_i has no effect; the operation completes.

Test Plan:
- DIVU 100/7, issue then hold start_i -> busy_o=1 for 33 cycles starting at the accept cycle; ready_o pulses 33 cycles after accept with result_o=14, reg_waddr_o = latched index.
- REM with 0xFFFF_FFF9 (-7) and 2 -> result_o=0xFFFF_FFFF (-1); DIV with the same operands -> 0xFFFF_FFFD (-3).
- DIVU 5/0 -> ready_o one cycle after accept with 0xFFFF_FFFF; REMU 5/0 -> 5; no CALC cycles.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 after 1 cycle; REM with the same operands -> 0.
- abort_i pulse at iteration 10 -> IDLE next cycle, busy_o low, no ready_o. A following DIVU 9/3 -> result 3, 33 cycles after its accept.
- rst asserted during CALC -> all outputs 0 at the next edge. Two back-to-back REMU ops (17%5, 20%6) -> ready pulses 34 cycles apart with results 2 and 2.
